// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: turns one AW/AR-style command into a stream of
// per-beat descriptors (byte address, lane mask, index, last) for FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int LEN_WIDTH  = 8,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [STRB_WIDTH-1:0] beat_strb,
  output logic [LEN_WIDTH-1:0]  beat_idx,
  output logic                  beat_last,
  output logic                  cmd_err
);

  localparam int MAX_SIZE = $clog2(STRB_WIDTH);
  // Wide enough that the page-crossing sum can never wrap silently.
  localparam int CW = ADDR_WIDTH + LEN_WIDTH + 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_enum_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  beat_valid_q, beat_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [2:0]            size_q, size_d;
  burst_enum_t           burst_q, burst_d;

  logic [ADDR_WIDTH-1:0] cmd_incr_s;
  logic [CW-1:0]         chk_first_s, chk_last_s;
  logic                  page_cross_s, wrap_len_ok_s, misaligned_s;
  logic                  burst_bad_s, size_bad_s, cmd_illegal_s;

  logic [ADDR_WIDTH-1:0] incr_s, aligned_s, step_s, wrap_bytes_s, lower_s, next_addr_s;

  // Lanes lo..hi, where lo is the address offset and hi the end of the aligned beat.
  function automatic logic [STRB_WIDTH-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0]            size);
    logic [ADDR_WIDTH-1:0] lo, hi, inc;
    logic [STRB_WIDTH-1:0] m;
    inc = ADDR_WIDTH'(1) << size;
    lo  = addr & ADDR_WIDTH'(STRB_WIDTH - 1);
    hi  = ((addr & ~(inc - ADDR_WIDTH'(1))) & ADDR_WIDTH'(STRB_WIDTH - 1)) + inc - ADDR_WIDTH'(1);
    for (int i = 0; i < STRB_WIDTH; i++) begin
      m[i] = (ADDR_WIDTH'(i) >= lo) && (ADDR_WIDTH'(i) <= hi);
    end
    return m;
  endfunction

  // Command legality check.
  always_comb begin
    cmd_incr_s    = ADDR_WIDTH'(1) << cmd_size;
    chk_first_s   = CW'(cmd_addr);
    chk_last_s    = (chk_first_s & ~(CW'(cmd_incr_s) - CW'(1)))
                  + ((CW'(cmd_len) + CW'(1)) << cmd_size) - CW'(1);
    page_cross_s  = chk_first_s[CW-1:12] != chk_last_s[CW-1:12];
    wrap_len_ok_s = (cmd_len == LEN_WIDTH'(1)) || (cmd_len == LEN_WIDTH'(3)) ||
                    (cmd_len == LEN_WIDTH'(7)) || (cmd_len == LEN_WIDTH'(15));
    misaligned_s  = (cmd_addr & (cmd_incr_s - ADDR_WIDTH'(1))) != '0;
    size_bad_s    = cmd_size > 3'(MAX_SIZE);
    case (burst_enum_t'(cmd_burst))
      BURST_FIXED: burst_bad_s = 1'b0;
      BURST_INCR:  burst_bad_s = page_cross_s;
      BURST_WRAP:  burst_bad_s = !wrap_len_ok_s || misaligned_s;
      default:     burst_bad_s = 1'b1;
    endcase
    cmd_illegal_s = burst_bad_s || size_bad_s;
  end

  // Address of the following beat for the burst in flight.
  always_comb begin
    incr_s       = ADDR_WIDTH'(1) << size_q;
    aligned_s    = addr_q & ~(incr_s - ADDR_WIDTH'(1));
    step_s       = aligned_s + incr_s;
    wrap_bytes_s = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    lower_s      = addr_q & ~(wrap_bytes_s - ADDR_WIDTH'(1));
    case (burst_q)
      BURST_FIXED: next_addr_s = addr_q;
      BURST_INCR:  next_addr_s = step_s;
      BURST_WRAP:  next_addr_s = (step_s == lower_s + wrap_bytes_s) ? lower_s : step_s;
      default:     next_addr_s = addr_q;
    endcase
  end

  // FSM next-state and registered output values.
  always_comb begin
    state_d      = state_q;
    beat_valid_d = beat_valid_q;
    addr_d       = addr_q;
    strb_d       = strb_q;
    idx_d        = idx_q;
    last_d       = last_q;
    err_d        = 1'b0;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_illegal_s) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d      = S_BURST;
            beat_valid_d = 1'b1;
            addr_d       = cmd_addr;
            strb_d       = lane_mask(cmd_addr, cmd_size);
            idx_d        = '0;
            last_d       = (cmd_len == '0);
            len_d        = cmd_len;
            size_d       = cmd_size;
            burst_d      = burst_enum_t'(cmd_burst);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (beat_ready) begin
          if (last_q) begin
            state_d      = S_IDLE;
            beat_valid_d = 1'b0;
            last_d       = 1'b0;
          end else begin
            addr_d = next_addr_s;
            strb_d = lane_mask(next_addr_s, size_q);
            idx_d  = idx_q + LEN_WIDTH'(1);
            last_d = ((idx_q + LEN_WIDTH'(1)) == len_q);
          end
        end else begin
          state_d = S_BURST;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        beat_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_valid_q <= 1'b0;
      addr_q       <= '0;
      strb_q       <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      len_q        <= '0;
      size_q       <= 3'd0;
      burst_q      <= BURST_FIXED;
    end else begin
      state_q      <= state_d;
      beat_valid_q <= beat_valid_d;
      addr_q       <= addr_d;
      strb_q       <= strb_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      err_q        <= err_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign beat_valid = beat_valid_q;
  assign beat_addr  = addr_q;
  assign beat_strb  = strb_q;
  assign beat_idx   = idx_q;
  assign beat_last  = last_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen: table of commands with expected beats,
// a scoreboard queue drained by a beat monitor, plus backpressure and reset sequences.
module tb_axi_burst_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        cmd_err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              err;
    logic [3:0][31:0]  eaddr;
    logic [3:0][3:0]   estrb;
  } vec_t;

  beat_t sb_q[$];
  beat_t exp_b;
  vec_t  vecs[13];

  axi_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_strb(beat_strb), .beat_idx(beat_idx), .beat_last(beat_last),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && beat_valid && beat_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got addr 0x%0h, want no beat", beat_addr);
      end else begin
        exp_b = sb_q.pop_front();
        check("beat_addr", 64'(beat_addr), 64'(exp_b.addr));
        check("beat_strb", 64'(beat_strb), 64'(exp_b.strb));
        check("beat_idx",  64'(beat_idx),  64'(exp_b.idx));
        check("beat_last", 64'(beat_last), 64'(exp_b.last));
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                              input logic [1:0] b, input logic e,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s3);
    vec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = b; v.err = e;
    v.eaddr[0] = a0; v.eaddr[1] = a1; v.eaddr[2] = a2; v.eaddr[3] = a3;
    v.estrb[0] = s0; v.estrb[1] = s1; v.estrb[2] = s2; v.estrb[3] = s3;
    return v;
  endfunction

  task automatic push_beat(input logic [31:0] a, input logic [3:0] s, input int i, input int len);
    beat_t b;
    b.addr = a; b.strb = s; b.idx = 8'(i); b.last = (i == len);
    sb_q.push_back(b);
  endtask

  task automatic drive_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain_and_idle(input string name);
    for (int k = 0; k < 64; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk); #1;
    end
    check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    @(negedge clk);
    check({name, "_ready_after"}, 64'(cmd_ready), 64'd1);
    check({name, "_valid_after"}, 64'(beat_valid), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string nm;
    nm = $sformatf("vec%0d", n);
    if (!v.err) begin
      for (int i = 0; i <= int'(v.len); i++) push_beat(v.eaddr[i], v.estrb[i], i, int'(v.len));
    end
    drive_cmd(v.addr, v.len, v.size, v.burst);
    if (v.err) begin
      @(negedge clk);
      check({nm, "_err_pulse"}, 64'(cmd_err), 64'd1);
      check({nm, "_err_novalid"}, 64'(beat_valid), 64'd0);
      check({nm, "_err_busy"}, 64'(cmd_ready), 64'd0);
      @(negedge clk);
      check({nm, "_err_cleared"}, 64'(cmd_err), 64'd0);
      check({nm, "_err_ready"}, 64'(cmd_ready), 64'd1);
      check({nm, "_err_novalid2"}, 64'(beat_valid), 64'd0);
    end else begin
      wait_drain_and_idle(nm);
    end
  endtask

  initial begin
    vecs[0]  = mk(32'h100, 8'd3, 3'd2, 2'd1, 1'b0, 32'h100, 32'h104, 32'h108, 32'h10C, 4'hF, 4'hF, 4'hF, 4'hF);
    vecs[1]  = mk(32'h101, 8'd2, 3'd2, 2'd1, 1'b0, 32'h101, 32'h104, 32'h108, 32'h0,   4'hE, 4'hF, 4'hF, 4'h0);
    vecs[2]  = mk(32'h01C, 8'd3, 3'd2, 2'd2, 1'b0, 32'h01C, 32'h010, 32'h014, 32'h018, 4'hF, 4'hF, 4'hF, 4'hF);
    vecs[3]  = mk(32'h042, 8'd2, 3'd0, 2'd0, 1'b0, 32'h042, 32'h042, 32'h042, 32'h0,   4'h4, 4'h4, 4'h4, 4'h0);
    vecs[4]  = mk(32'h100, 8'd1, 3'd2, 2'd3, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[5]  = mk(32'h100, 8'd2, 3'd2, 2'd2, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[6]  = mk(32'h102, 8'd3, 3'd2, 2'd2, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[7]  = mk(32'hFF8, 8'd3, 3'd2, 2'd1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[8]  = mk(32'h100, 8'd0, 3'd3, 2'd1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vecs[9]  = mk(32'h203, 8'd1, 3'd1, 2'd1, 1'b0, 32'h203, 32'h204, 32'h0, 32'h0, 4'h8, 4'h3, 4'h0, 4'h0);
    vecs[10] = mk(32'hFF0, 8'd3, 3'd2, 2'd1, 1'b0, 32'hFF0, 32'hFF4, 32'hFF8, 32'hFFC, 4'hF, 4'hF, 4'hF, 4'hF);
    vecs[11] = mk(32'h034, 8'd1, 3'd2, 2'd2, 1'b0, 32'h034, 32'h030, 32'h0, 32'h0, 4'hF, 4'hF, 4'h0, 4'h0);
    vecs[12] = mk(32'h010, 8'd0, 3'd2, 2'd0, 1'b0, 32'h010, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    beat_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(beat_valid), 64'd0);
    check("rst_addr",  64'(beat_addr),  64'd0);
    check("rst_strb",  64'(beat_strb),  64'd0);
    check("rst_idx",   64'(beat_idx),   64'd0);
    check("rst_last",  64'(beat_last),  64'd0);
    check("rst_err",   64'(cmd_err),    64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd1);

    for (int n = 0; n < 13; n++) run_vec(vecs[n], n);

    // Backpressure: stall beat 1 for three cycles.
    for (int i = 0; i < 4; i++) push_beat(32'h200 + 32'(4 * i), 4'hF, i, 3);
    drive_cmd(32'h200, 8'd3, 3'd2, 2'd1);
    @(posedge clk); #1;
    beat_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(beat_valid), 64'd1);
      check("bp_addr",  64'(beat_addr),  64'h204);
      check("bp_strb",  64'(beat_strb),  64'hF);
      check("bp_idx",   64'(beat_idx),   64'd1);
      check("bp_last",  64'(beat_last),  64'd0);
    end
    @(posedge clk); #1;
    beat_ready = 1'b1;
    wait_drain_and_idle("bp");

    // Reset while beat 2 of an 8-beat INCR is presented.
    push_beat(32'h300, 4'hF, 0, 7);
    push_beat(32'h304, 4'hF, 1, 7);
    drive_cmd(32'h300, 8'd7, 3'd2, 2'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_beat2_addr", 64'(beat_addr), 64'h308);
    rst = 1'b1; beat_ready = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", 64'(beat_valid), 64'd0);
    check("mid_rst_addr",  64'(beat_addr),  64'd0);
    check("mid_rst_strb",  64'(beat_strb),  64'd0);
    check("mid_rst_idx",   64'(beat_idx),   64'd0);
    check("mid_rst_last",  64'(beat_last),  64'd0);
    check("mid_rst_sb",    64'(sb_q.size()), 64'd0);
    sb_q.delete();
    rst = 1'b0; beat_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(cmd_ready), 64'd1);
    push_beat(32'h400, 4'hF, 0, 1);
    push_beat(32'h404, 4'hF, 1, 1);
    drive_cmd(32'h400, 8'd1, 3'd2, 2'd1);
    wait_drain_and_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
